fpu_op_sequencer: RTL and testbench

- Issue/completion controller between core decode and the FPU arithmetic datapath (classifier, sign-inject/compare, add/mul/fma pipe, iterative div/sqrt).
- Accepts one FP operation at a time over a valid/ready handshake and starts the selected unit.
- Times or waits for unit completion, captures the result and exception flags, and holds them until the core accepts them.
- Keeps the sticky fflags accumulator and supports pipeline flush.

---
 rtl/fpu_op_sequencer_if.sv | 63 ++++++
 rtl/fpu_op_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_fpu_op_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fpu_op_sequencer_if.sv
// Signal bundle between core decode, the FPU arithmetic units and the op sequencer.
// The slave side is the sequencer. The master side is the core and datapath that drive it.
interface fpu_op_sequencer_if #(
  parameter int XLEN = 32
);
  logic            req_valid_i;
  logic            req_ready_o;
  logic [1:0]      op_class_i;
  logic            flush_i;
  logic            unit_start_o;
  logic [1:0]      unit_sel_o;
  logic            unit_done_i;
  logic            unit_abort_o;
  logic [XLEN-1:0] result_i;
  logic [4:0]      flags_i;
  logic            resp_valid_o;
  logic            resp_ready_i;
  logic [XLEN-1:0] resp_data_o;
  logic            resp_illegal_o;
  logic [4:0]      fflags_o;
  logic            fflags_clr_i;
  logic            busy_o;

  modport slave (
    input  req_valid_i,
    input  op_class_i,
    input  flush_i,
    input  unit_done_i,
    input  result_i,
    input  flags_i,
    input  resp_ready_i,
    input  fflags_clr_i,
    output req_ready_o,
    output unit_start_o,
    output unit_sel_o,
    output unit_abort_o,
    output resp_valid_o,
    output resp_data_o,
    output resp_illegal_o,
    output fflags_o,
    output busy_o
  );

  modport master (
    output req_valid_i,
    output op_class_i,
    output flush_i,
    output unit_done_i,
    output result_i,
    output flags_i,
    output resp_ready_i,
    output fflags_clr_i,
    input  req_ready_o,
    input  unit_start_o,
    input  unit_sel_o,
    input  unit_abort_o,
    input  resp_valid_o,
    input  resp_data_o,
    input  resp_illegal_o,
    input  fflags_o,
    input  busy_o
  );
endinterface

// File: rtl/fpu_op_sequencer.sv
// Single-issue controller for the FPU datapath. It starts one unit, then times or awaits its
// completion, holds the response until the core takes it, and keeps the sticky fflags.
module fpu_op_sequencer #(
  parameter int PIPE_LAT = 3,
  parameter int TIMEOUT  = 64,
  parameter int XLEN     = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  fpu_op_sequencer_if.slave bus
);

  localparam int CNT_W = 4;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(PIPE_LAT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PIPE = 2'd1,
    S_ITER = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [TMO_W-1:0] r_tmo;
  logic             r_resp_valid;
  logic             r_resp_illegal;
  logic [XLEN-1:0]  r_resp_data;
  logic [4:0]       r_fflags;
  logic             r_start;
  logic             r_abort;
  logic [1:0]       r_sel;

  logic w_req_ready;
  logic w_accept;
  logic w_timeout;
  logic w_resp_done;
  logic w_cap_ok;
  logic w_cap_ill;
  logic w_start_next;
  logic w_abort_next;

  assign w_req_ready = (r_state == S_IDLE) & ~bus.flush_i;
  assign w_accept    = bus.req_valid_i & w_req_ready;
  assign w_timeout   = (r_tmo == TMO_LAST);
  assign w_resp_done = r_resp_valid & bus.resp_ready_i;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Flush outranks every other exit from a busy state.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (bus.op_class_i)
            2'd1:    w_state_next = S_PIPE;
            2'd2:    w_state_next = S_ITER;
            default: w_state_next = S_RESP;
          endcase
        end
      end
      S_PIPE: begin
        if (bus.flush_i) begin
          w_state_next = S_IDLE;
        end else if (r_cnt == CNT_W'(1)) begin
          w_state_next = S_RESP;
        end
      end
      S_ITER: begin
        if (bus.flush_i) begin
          w_state_next = S_IDLE;
        end else if (bus.unit_done_i || w_timeout) begin
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.flush_i || w_resp_done) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cap_ok     = 1'b0;
    w_cap_ill    = 1'b0;
    w_start_next = 1'b0;
    w_abort_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (bus.op_class_i)
            2'd0:    w_cap_ok     = 1'b1;
            2'd3:    w_cap_ill    = 1'b1;
            default: w_start_next = 1'b1;
          endcase
        end
      end
      S_PIPE: begin
        w_cap_ok = ~bus.flush_i & (r_cnt == CNT_W'(1));
      end
      S_ITER: begin
        // Done wins a tie with the timeout, so the abort only goes out on a real expiry.
        if (bus.flush_i) begin
          w_abort_next = 1'b1;
        end else if (bus.unit_done_i) begin
          w_cap_ok = 1'b1;
        end else if (w_timeout) begin
          w_cap_ill    = 1'b1;
          w_abort_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_cnt <= '0;
      r_tmo <= '0;
    end else begin
      if (w_accept && (bus.op_class_i == 2'd1)) begin
        r_cnt <= CNT_INIT;
      end else if ((r_state == S_PIPE) && (w_state_next == S_PIPE)) begin
        r_cnt <= r_cnt - 1'b1;
      end else begin
        r_cnt <= '0;
      end
      if ((r_state == S_ITER) && (w_state_next == S_ITER)) begin
        r_tmo <= r_tmo + 1'b1;
      end else begin
        r_tmo <= '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_start <= 1'b0;
      r_abort <= 1'b0;
      r_sel   <= 2'd0;
    end else begin
      r_start <= w_start_next;
      r_abort <= w_abort_next;
      if (w_accept) begin
        r_sel <= bus.op_class_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_resp_valid   <= 1'b0;
      r_resp_illegal <= 1'b0;
      r_resp_data    <= '0;
    end else begin
      if (w_cap_ok) begin
        r_resp_valid   <= 1'b1;
        r_resp_illegal <= 1'b0;
        r_resp_data    <= bus.result_i;
      end else if (w_cap_ill) begin
        r_resp_valid   <= 1'b1;
        r_resp_illegal <= 1'b1;
        r_resp_data    <= '0;
      end else if ((r_state == S_RESP) && (bus.flush_i || w_resp_done)) begin
        r_resp_valid   <= 1'b0;
        r_resp_illegal <= 1'b0;
      end
    end
  end

  // A capture that lands on a CSR clear keeps only the new flags.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_fflags <= '0;
    end else if (w_cap_ok) begin
      r_fflags <= (bus.fflags_clr_i ? 5'd0 : r_fflags) | bus.flags_i;
    end else if (bus.fflags_clr_i) begin
      r_fflags <= '0;
    end
  end

  assign bus.req_ready_o    = w_req_ready;
  assign bus.unit_start_o   = r_start;
  assign bus.unit_abort_o   = r_abort;
  assign bus.unit_sel_o     = r_sel;
  assign bus.resp_valid_o   = r_resp_valid;
  assign bus.resp_illegal_o = r_resp_illegal;
  assign bus.resp_data_o    = r_resp_data;
  assign bus.fflags_o       = r_fflags;
  assign bus.busy_o         = (r_state != S_IDLE);

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Randomized bench for fpu_op_sequencer. Each operation's timeline is derived from its
// class, its completion time, its flush point and the core's response delay.
module tb_fpu_op_sequencer;
  localparam int PIPE_LAT = 3;
  localparam int TIMEOUT  = 64;
  localparam int XLEN     = 32;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b0;
  always #5 clk_i = ~clk_i;

  fpu_op_sequencer_if #(.XLEN(XLEN)) bus ();

  fpu_op_sequencer #(
    .PIPE_LAT (PIPE_LAT),
    .TIMEOUT  (TIMEOUT),
    .XLEN     (XLEN)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int         checks = 0;
  int         errors = 0;
  int         op_num = 0;
  logic [4:0] m_fflags;
  logic [1:0] m_sel;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h (op %0d, t=%0t)", tag, obs, exp, op_num, $time);
    end
  endtask

  // Sticky flag register as seen after one clock edge.
  task automatic model_edge(input logic clr, input logic cap, input logic [4:0] flags);
    if (cap) m_fflags = (clr ? 5'd0 : m_fflags) | flags;
    else if (clr) m_fflags = 5'd0;
  endtask

  // Cycle 0 is the accept cycle. cap is the cycle whose closing edge captures the result.
  // A flush at cycle f (f > 0) ends the operation at f. Otherwise the handshake at r ends it.
  task automatic run_op(input int cls, input int d_done, input int w, input int f_in,
                        input logic [31:0] cap_data, input logic [4:0] cap_flags, input logic cap_clr);
    int          cap, r, f, last;
    logic        tmo, ill, fb, clr, vld_exp, abort_exp;
    logic [31:0] exp_data;
    cap = (cls == 1) ? PIPE_LAT : (cls == 2) ? ((d_done <= TIMEOUT) ? d_done : TIMEOUT) : 0;
    tmo = (cls == 2) && (d_done > TIMEOUT);
    ill = (cls == 3) || tmo;
    r   = cap + 1 + w;
    f   = f_in;
    if (f < 0) f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, r)) : 0;
    fb       = (f >= 1) && (f <= cap);
    last     = (f != 0) ? f : r;
    exp_data = ill ? 32'd0 : cap_data;
    for (int c = 0; c <= last + 1; c++) begin
      @(posedge clk_i); #1;
      bus.req_valid_i  = (c == 0) ? 1'b1 : (c == last + 1) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.op_class_i   = (c == 0) ? 2'(cls) : 2'($urandom_range(0, 3));
      bus.flush_i      = (f != 0) && (c == f);
      bus.unit_done_i  = (cls == 2) ? (c == d_done) : 1'($urandom_range(0, 1));
      bus.result_i     = (c == cap) ? cap_data : $urandom;
      bus.flags_i      = (c == cap) ? cap_flags : 5'($urandom);
      clr              = (c == cap) ? cap_clr : ($urandom_range(0, 7) == 0);
      bus.fflags_clr_i = clr;
      bus.resp_ready_i = (c > cap && c < r) ? 1'b0 : (c >= r) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk_i);
      vld_exp   = !fb && (c > cap) && (c <= last);
      abort_exp = (cls == 2) && ((fb && c == f + 1) || (!fb && tmo && c == cap + 1));
      check_val("req_ready", 32'(bus.req_ready_o), 32'(c == 0 || c == last + 1));
      check_val("busy", 32'(bus.busy_o), 32'(c >= 1 && c <= last));
      check_val("resp_valid", 32'(bus.resp_valid_o), 32'(vld_exp));
      if (vld_exp) begin
        check_val("resp_data", bus.resp_data_o, exp_data);
        check_val("resp_illegal", 32'(bus.resp_illegal_o), 32'(ill));
      end
      check_val("unit_start", 32'(bus.unit_start_o), 32'(c == 1 && (cls == 1 || cls == 2)));
      check_val("unit_abort", 32'(bus.unit_abort_o), 32'(abort_exp));
      check_val("unit_sel", 32'(bus.unit_sel_o), 32'((c == 0) ? m_sel : 2'(cls)));
      check_val("fflags", 32'(bus.fflags_o), 32'(m_fflags));
      model_edge(clr, (c == cap) && !fb && !ill, cap_flags);
    end
    m_sel = 2'(cls);
    $display("op %0d class=%0d cap=%0d flush=%0d dropped=%0d illegal=%0d data=%h fflags=%b",
             op_num, cls, cap, f, fb, ill, exp_data, m_fflags);
    op_num++;
  endtask

  // Idle cycles with a request blocked by a simultaneous flush.
  task automatic idle_gap(input int n);
    logic clr;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      bus.req_valid_i  = 1'b1;
      bus.flush_i      = 1'b1;
      bus.op_class_i   = 2'($urandom_range(0, 3));
      bus.unit_done_i  = 1'($urandom_range(0, 1));
      bus.resp_ready_i = 1'($urandom_range(0, 1));
      bus.result_i     = $urandom;
      bus.flags_i      = 5'($urandom);
      clr              = ($urandom_range(0, 3) == 0);
      bus.fflags_clr_i = clr;
      @(negedge clk_i);
      check_val("gap_req_ready", 32'(bus.req_ready_o), 32'd0);
      check_val("gap_busy", 32'(bus.busy_o), 32'd0);
      check_val("gap_resp_valid", 32'(bus.resp_valid_o), 32'd0);
      check_val("gap_fflags", 32'(bus.fflags_o), 32'(m_fflags));
      model_edge(clr, 1'b0, 5'd0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_resp_valid"}, 32'(bus.resp_valid_o), 32'd0);
    check_val({tag, "_resp_data"}, bus.resp_data_o, 32'd0);
    check_val({tag, "_resp_illegal"}, 32'(bus.resp_illegal_o), 32'd0);
    check_val({tag, "_fflags"}, 32'(bus.fflags_o), 32'd0);
    check_val({tag, "_unit_start"}, 32'(bus.unit_start_o), 32'd0);
    check_val({tag, "_unit_abort"}, 32'(bus.unit_abort_o), 32'd0);
    check_val({tag, "_unit_sel"}, 32'(bus.unit_sel_o), 32'd0);
    check_val({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cls, d_done;
    bus.req_valid_i  = 1'b0;
    bus.op_class_i   = 2'd0;
    bus.flush_i      = 1'b0;
    bus.unit_done_i  = 1'b0;
    bus.result_i     = '0;
    bus.flags_i      = '0;
    bus.resp_ready_i = 1'b0;
    bus.fflags_clr_i = 1'b0;
    m_fflags = 5'd0;
    m_sel    = 2'd0;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_values("reset");
    reset_i = 1'b1;

    run_op(0, 0, 2, 0, 32'h0000_0200, 5'b00000, 1'b0);
    run_op(1, 0, 5, 0, $urandom, 5'b00001, 1'b0);
    run_op(2, 20, 1, 0, $urandom, 5'($urandom), 1'b0);
    run_op(2, TIMEOUT + 50, 1, 0, $urandom, 5'($urandom), 1'b0);
    run_op(2, TIMEOUT, 0, 0, $urandom, 5'b01000, 1'b0);
    run_op(3, 0, 3, 0, $urandom, 5'($urandom), 1'b0);
    run_op(2, 10, 0, 10, $urandom, 5'b10000, 1'b0);
    run_op(1, 0, 2, 2, $urandom, 5'b00010, 1'b0);
    run_op(0, 0, 4, 3, $urandom, 5'b00010, 1'b0);
    run_op(0, 0, 1, 0, $urandom, 5'b00100, 1'b1);
    idle_gap(2);

    // Asynchronous reset in the middle of a pipelined operation.
    @(posedge clk_i); #1;
    bus.req_valid_i  = 1'b1;
    bus.op_class_i   = 2'd1;
    bus.flush_i      = 1'b0;
    bus.fflags_clr_i = 1'b0;
    @(negedge clk_i);
    check_val("rst_accept", 32'(bus.req_ready_o), 32'd1);
    @(posedge clk_i); #1;
    bus.req_valid_i = 1'b0;
    @(negedge clk_i);
    check_val("rst_pipe_busy", 32'(bus.busy_o), 32'd1);
    #1 reset_i = 1'b0;
    #1;
    check_reset_values("midreset");
    m_fflags = 5'd0;
    m_sel    = 2'd0;
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    run_op(1, 0, 0, 0, $urandom, 5'b00001, 1'b0);

    for (int n = 0; n < 60; n++) begin
      cls    = int'($urandom_range(0, 3));
      d_done = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TIMEOUT - 1, TIMEOUT + 8))
                                           : int'($urandom_range(1, 40));
      run_op(cls, d_done, int'($urandom_range(0, 5)), -1, $urandom, 5'($urandom),
             1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 4) == 0) idle_gap(int'($urandom_range(1, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
